// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// alu_pkg : opcode encodings and flag bit positions for the ALU result stage
// Revision: 1.0
// ============================================================================
package alu_pkg;

  localparam logic [2:0] OP_OR  = 3'b000;
  localparam logic [2:0] OP_AND = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_ADD = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b100;

  localparam int FLAG_W = 4;
  localparam int FLG_Z  = 3;
  localparam int FLG_N  = 2;
  localparam int FLG_C  = 1;
  localparam int FLG_V  = 0;

endpackage
`default_nettype wire

// File: rtl/alu_flag_gen.sv
`default_nettype none
// ============================================================================
// alu_flag_gen : selects the unit result for the opcode and derives Z/N/C/V
// Revision: 1.0
// ============================================================================
module alu_flag_gen
  import alu_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] or_bus,
  input  logic [DATA_W-1:0] and_bus,
  input  logic [DATA_W-1:0] xor_bus,
  input  logic [DATA_W-1:0] sum,
  input  logic              cout,
  input  logic              a_msb,
  input  logic              b_msb,
  output logic [DATA_W-1:0] res,
  output logic [FLAG_W-1:0] flags,
  output logic              illegal
);

  logic w_c;
  logic w_v;
  logic w_sum_msb;

  assign w_sum_msb = sum[DATA_W-1];

  always_comb begin
    res     = '0;
    w_c     = 1'b0;
    w_v     = 1'b0;
    illegal = 1'b0;
    case (op)
      OP_OR:  res = or_bus;
      OP_AND: res = and_bus;
      OP_XOR: res = xor_bus;
      OP_ADD: begin
        res = sum;
        w_c = cout;
        w_v = (a_msb == b_msb) && (w_sum_msb != a_msb);
      end
      // B was inverted inside the adder, so overflow needs unlike operand signs
      OP_SUB: begin
        res = sum;
        w_c = cout;
        w_v = (a_msb != b_msb) && (w_sum_msb != a_msb);
      end
      default: illegal = 1'b1;
    endcase
  end

  always_comb begin
    flags        = '0;
    flags[FLG_Z] = (res == '0);
    flags[FLG_N] = res[DATA_W-1];
    flags[FLG_C] = w_c;
    flags[FLG_V] = w_v;
  end

endmodule
`default_nettype wire

// File: rtl/alu_result_stage.sv
`default_nettype none
// ============================================================================
// alu_result_stage : queues selected ALU result + flags toward writeback
// Revision: 1.0
// ============================================================================
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [DATA_W-1:0] in_or,
  input  logic [DATA_W-1:0] in_and,
  input  logic [DATA_W-1:0] in_xor,
  input  logic [DATA_W-1:0] in_sum,
  input  logic              in_cout,
  input  logic              in_a_msb,
  input  logic              in_b_msb,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_res,
  output logic [FLAG_W-1:0] out_flags,
  output logic [CNT_W-1:0]  out_cnt,
  output logic              err,
  input  logic              err_clr
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_OCC_W = c_PTR_W + 1;
  localparam int c_ENT_W = DATA_W + FLAG_W;
  localparam logic [c_OCC_W-1:0] c_FULL = c_OCC_W'(DEPTH);

  logic [c_ENT_W-1:0] r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_OCC_W-1:0] r_occ;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_err;

  logic [DATA_W-1:0]  w_res;
  logic [FLAG_W-1:0]  w_flags;
  logic               w_illegal;
  logic               w_accept;
  logic               w_push;
  logic               w_pop;

  alu_flag_gen #(
    .DATA_W (DATA_W)
  ) u_flag_gen (
    .op      (in_op),
    .or_bus  (in_or),
    .and_bus (in_and),
    .xor_bus (in_xor),
    .sum     (in_sum),
    .cout    (in_cout),
    .a_msb   (in_a_msb),
    .b_msb   (in_b_msb),
    .res     (w_res),
    .flags   (w_flags),
    .illegal (w_illegal)
  );

  // Ready comes from registered occupancy only, so no path from out_ready
  assign in_ready  = (r_occ != c_FULL);
  assign out_valid = (r_occ != '0);
  assign w_accept  = in_valid && in_ready;
  assign w_push    = w_accept && !w_illegal;
  assign w_pop     = out_valid && out_ready;

  assign {out_res, out_flags} = r_mem[r_rd_ptr];
  assign out_cnt = r_cnt;
  assign err     = r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= {w_res, w_flags};
        r_wr_ptr        <= r_wr_ptr + c_PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + c_OCC_W'(1);
        2'b01:   r_occ <= r_occ - c_OCC_W'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_pop && (r_cnt != '1)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // A new illegal accept takes priority over a clear in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_accept && w_illegal) begin
      r_err <= 1'b1;
    end else if (err_clr) begin
      r_err <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_result_stage.sv
`default_nettype none
// ============================================================================
// tb_alu_result_stage : directed + random checks against a queue-based model
// Revision: 1.0
// ============================================================================
module tb_alu_result_stage;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 2;
  localparam int CNT_W  = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_op;
  logic [DATA_W-1:0] in_or;
  logic [DATA_W-1:0] in_and;
  logic [DATA_W-1:0] in_xor;
  logic [DATA_W-1:0] in_sum;
  logic              in_cout;
  logic              in_a_msb;
  logic              in_b_msb;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_res;
  logic [3:0]        out_flags;
  logic [CNT_W-1:0]  out_cnt;
  logic              err;
  logic              err_clr;

  alu_result_stage #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_or     (in_or),
    .in_and    (in_and),
    .in_xor    (in_xor),
    .in_sum    (in_sum),
    .in_cout   (in_cout),
    .in_a_msb  (in_a_msb),
    .in_b_msb  (in_b_msb),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .out_flags (out_flags),
    .out_cnt   (out_cnt),
    .err       (err),
    .err_clr   (err_clr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] res;
    logic [3:0]  flags;
  } ent_t;

  int   checks   = 0;
  int   failures = 0;
  ent_t q[$];
  ent_t m_next;
  int   m_cnt = 0;
  bit   m_err = 1'b0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected entry from the true operands using integer arithmetic
  function automatic ent_t exp_of(logic [2:0] op, logic [15:0] a, logic [15:0] b);
    ent_t        e;
    logic [16:0] full;
    int          sa, sb, s;
    bit          c, v;
    sa = int'($signed(a));
    sb = int'($signed(b));
    c = 1'b0;
    v = 1'b0;
    e.res = 16'h0;
    case (op)
      3'd0: e.res = a | b;
      3'd1: e.res = a & b;
      3'd2: e.res = a ^ b;
      3'd3: begin
        full = {1'b0, a} + {1'b0, b};
        e.res = full[15:0];
        c = full[16];
        s = sa + sb;
        v = (s > 32767) || (s < -32768);
      end
      3'd4: begin
        full = {1'b0, a} + {1'b0, ~b} + 17'd1;
        e.res = full[15:0];
        c = full[16];
        s = sa - sb;
        v = (s > 32767) || (s < -32768);
      end
      default: ;
    endcase
    e.flags = {(e.res == 16'h0), e.res[15], c, v};
    return e;
  endfunction

  task automatic drive(bit v, logic [2:0] op, logic [15:0] a, logic [15:0] b);
    logic [16:0] full;
    in_valid = v;
    in_op    = op;
    in_or    = a | b;
    in_and   = a & b;
    in_xor   = a ^ b;
    full = (op == 3'd4) ? ({1'b0, a} + {1'b0, ~b} + 17'd1) : ({1'b0, a} + {1'b0, b});
    in_sum   = full[15:0];
    in_cout  = full[16];
    in_a_msb = a[15];
    in_b_msb = b[15];
    m_next   = exp_of(op, a, b);
  endtask

  task automatic check_state();
    chk("in_ready", in_ready, (q.size() < DEPTH));
    chk("out_valid", out_valid, (q.size() > 0));
    chk("out_cnt", out_cnt, m_cnt);
    chk("err", err, m_err);
    if (q.size() > 0) begin
      chk("out_res", out_res, q[0].res);
      chk("out_flags", out_flags, q[0].flags);
    end
  endtask

  // One clock: predict from pre-edge state, advance model, compare
  task automatic cycle();
    bit acc, pop, ill;
    acc = in_valid && (q.size() < DEPTH);
    pop = (q.size() > 0) && out_ready;
    ill = (in_op > 3'd4);
    @(posedge clk);
    #1;
    if (rst) begin
      q.delete();
      m_cnt = 0;
      m_err = 1'b0;
    end else begin
      if (pop) begin
        void'(q.pop_front());
        if (m_cnt < CNT_MAX) m_cnt++;
      end
      if (acc && !ill) q.push_back(m_next);
      if (acc && ill) m_err = 1'b1;
      else if (err_clr) m_err = 1'b0;
    end
    check_state();
  endtask

  initial begin
    // Reset held two cycles with a valid op present
    rst = 1'b1; out_ready = 1'b0; err_clr = 1'b0;
    drive(1'b1, 3'd0, 16'h1234, 16'h0001);
    cycle();
    cycle();
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_cnt", out_cnt, 0);
    chk("rst_err", err, 1'b0);
    chk("rst_out_res", out_res, 16'h0);
    chk("rst_out_flags", out_flags, 4'h0);
    rst = 1'b0;
    drive(1'b0, 3'd0, 16'h0, 16'h0);
    cycle();
    chk("rst_in_ready", in_ready, 1'b1);

    // OR result and first delivery
    out_ready = 1'b1;
    drive(1'b1, 3'd0, 16'hF0F0, 16'h0000);
    cycle();
    chk("or_res", out_res, 16'hF0F0);
    chk("or_flags", out_flags, 4'b0100);
    drive(1'b0, 3'd0, 16'h0, 16'h0);
    cycle();
    chk("or_cnt", out_cnt, 1);

    // ADD signed overflow, then SUB to zero without borrow
    drive(1'b1, 3'd3, 16'h4000, 16'h4000);
    cycle();
    chk("add_res", out_res, 16'h8000);
    chk("add_flags", out_flags, 4'b0101);
    drive(1'b1, 3'd4, 16'h1234, 16'h1234);
    cycle();
    chk("sub_res", out_res, 16'h0000);
    chk("sub_flags", out_flags, 4'b1010);
    drive(1'b0, 3'd0, 16'h0, 16'h0);
    cycle();

    // Backpressure: two fill the queue, third waits
    out_ready = 1'b0;
    drive(1'b1, 3'd2, 16'h0001, 16'h0002);
    cycle();
    drive(1'b1, 3'd2, 16'h0003, 16'h0004);
    cycle();
    chk("bp_full_ready", in_ready, 1'b0);
    drive(1'b1, 3'd2, 16'h0005, 16'h0006);
    cycle();
    chk("bp_stall_ready", in_ready, 1'b0);
    chk("bp_head0", out_res, 16'h0003);
    out_ready = 1'b1;
    cycle();
    chk("bp_head1", out_res, 16'h0007);
    cycle();
    chk("bp_head2", out_res, 16'h0003);
    drive(1'b0, 3'd0, 16'h0, 16'h0);
    cycle();
    chk("bp_empty", out_valid, 1'b0);

    // Illegal opcode, clear, and set-wins collision
    drive(1'b1, 3'd6, 16'hAAAA, 16'h5555);
    cycle();
    chk("ill_err", err, 1'b1);
    chk("ill_no_valid", out_valid, 1'b0);
    chk("ill_ready", in_ready, 1'b1);
    drive(1'b0, 3'd0, 16'h0, 16'h0);
    err_clr = 1'b1;
    cycle();
    chk("clr_err", err, 1'b0);
    drive(1'b1, 3'd7, 16'h0, 16'h0);
    cycle();
    chk("set_wins_err", err, 1'b1);
    drive(1'b0, 3'd0, 16'h0, 16'h0);
    cycle();
    err_clr = 1'b0;

    // Random traffic long enough to saturate the delivered counter
    for (int i = 0; i < 1500; i++) begin
      drive(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
            16'($urandom), 16'($urandom));
      out_ready = ($urandom_range(0, 3) != 0);
      err_clr   = ($urandom_range(0, 7) == 0);
      cycle();
    end
    drive(1'b0, 3'd0, 16'h0, 16'h0);
    out_ready = 1'b1;
    err_clr   = 1'b0;
    cycle();
    cycle();
    chk("cnt_saturated", out_cnt, CNT_MAX);

    // Reset while full discards everything
    out_ready = 1'b0;
    drive(1'b1, 3'd3, 16'h0011, 16'h0022);
    cycle();
    drive(1'b1, 3'd1, 16'hFF00, 16'h0FF0);
    cycle();
    chk("full_before_rst", in_ready, 1'b0);
    rst = 1'b1;
    drive(1'b0, 3'd0, 16'h0, 16'h0);
    cycle();
    rst = 1'b0;
    chk("post_rst_valid", out_valid, 1'b0);
    chk("post_rst_ready", in_ready, 1'b1);
    chk("post_rst_cnt", out_cnt, 0);
    out_ready = 1'b1;
    cycle();
    chk("post_rst_no_delivery", out_valid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
